// File: rtl/alert_pkg.sv
// Shared widths, record layout and FSM encoding for the alert collector.
package alert_pkg;
   localparam int unsigned RULE_W_DEF      = 11;
   localparam int unsigned PKT_W_DEF       = 7;
   localparam int unsigned DEDUP_DEPTH_DEF = 8;
   localparam int unsigned FIFO_DEPTH_DEF  = 16;
   localparam int unsigned N_SRC           = 3;
   localparam int unsigned PAY_W           = 12;
   localparam int unsigned REC_W           = 1 + PKT_W_DEF + PAY_W;
   localparam int unsigned UCNT_W          = 10;
   localparam int unsigned DROP_W          = 8;

   localparam logic REC_ALERT   = 1'b0;
   localparam logic REC_SUMMARY = 1'b1;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_FLUSH   = 2'd1,
      ST_CLEAR   = 2'd2
   } state_e;

   // Output record: [19] type, [18:12] packet ID, [11:0] payload
   typedef struct packed {
      logic                 rtype;
      logic [PKT_W_DEF-1:0] pkt;
      logic [PAY_W-1:0]     payload;
   } rec_t;

   function automatic rec_t mk_rec(input logic rtype, input logic [PKT_W_DEF-1:0] pkt,
                                   input logic [PAY_W-1:0] payload);
      rec_t r;
      r.rtype   = rtype;
      r.pkt     = pkt;
      r.payload = payload;
      return r;
   endfunction
endpackage

// File: rtl/alert_fifo.sv
// Synchronous record FIFO with valid/ready read side; head entry is held until accepted.
module alert_fifo #(
   parameter int unsigned W     = 20,
   parameter int unsigned DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_wr_valid,
   input  logic [W-1:0] i_wr_data,
   output logic         o_full,
   output logic         o_rd_valid,
   input  logic         i_rd_ready,
   output logic [W-1:0] o_rd_data
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   // A full FIFO refuses writes even when a read happens in the same cycle
   assign o_full     = (r_count == CW'(DEPTH));
   assign o_rd_valid = (r_count != '0);
   assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;
   assign w_push     = i_wr_valid && !o_full;
   assign w_pop      = o_rd_valid && i_rd_ready;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/alert_collector.sv
// Stages rule hits from three sources, dedups them per packet and streams alert/summary records.
// Build option: define ALERT_DROP_CNT_EN to include the saturating dropped-hit counter.
module alert_collector
   import alert_pkg::*;
#(
   parameter int unsigned RULE_W      = RULE_W_DEF,
   parameter int unsigned PKT_W       = PKT_W_DEF,
   parameter int unsigned DEDUP_DEPTH = DEDUP_DEPTH_DEF,
   parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [RULE_W-1:0] hit_id0,
   input  logic [RULE_W-1:0] hit_id1,
   input  logic [RULE_W-1:0] hit_id2,
   input  logic [PKT_W-1:0]  cur_packet_id,
   input  logic              end_of_packet,
   input  logic              filter_trigger,
   output logic              alert_valid,
   input  logic              alert_ready,
   output logic [REC_W-1:0]  alert_data,
   output logic              busy,
   output logic [DROP_W-1:0] drop_count
);
   localparam int unsigned SEL_W  = 2;
   localparam int unsigned CAM_IW = $clog2(DEDUP_DEPTH);
   localparam int unsigned CAM_CW = $clog2(DEDUP_DEPTH + 1);

   logic [RULE_W-1:0] w_hit  [N_SRC];
   logic [RULE_W-1:0] r_id   [N_SRC];
   logic [PKT_W-1:0]  r_tag  [N_SRC];
   logic [N_SRC-1:0]  r_pend;
   logic [RULE_W-1:0] r_cam  [DEDUP_DEPTH];
   logic [CAM_CW-1:0] r_cam_cnt;
   logic [UCNT_W-1:0] r_ucnt;
   logic [PKT_W-1:0]  r_closing;
   logic              r_filter_seen;
   logic              r_filter_next;
   logic              r_cam_ovf;
   state_e            r_state;

   logic [N_SRC-1:0]  w_elig;
   logic [N_SRC-1:0]  w_load;
   logic [N_SRC-1:0]  w_pend_nxt;
   logic [SEL_W-1:0]  w_sel;
   logic              w_any_elig;
   logic              w_cam_hit;
   logic              w_drain;
   logic              w_alert_wr;
   logic              w_sum_wr;
   logic              w_fifo_full;
   rec_t              w_wr_rec;

   assign w_hit[0] = hit_id0;
   assign w_hit[1] = hit_id1;
   assign w_hit[2] = hit_id2;

   // Arbitration, CAM lookup, FIFO write selection and staging slot updates
   always_comb begin
      w_elig     = '0;
      w_load     = '0;
      w_pend_nxt = '0;
      w_sel      = '0;
      w_cam_hit  = 1'b0;
      for (int i = 0; i < N_SRC; i++)
         w_elig[i] = r_pend[i] && ((r_state == ST_COLLECT) ||
                     ((r_state == ST_FLUSH) && (r_tag[i] == r_closing)));
      w_any_elig = |w_elig;
      for (int i = N_SRC - 1; i >= 0; i--)
         if (w_elig[i]) w_sel = SEL_W'(i);
      for (int i = 0; i < DEDUP_DEPTH; i++)
         if ((CAM_CW'(i) < r_cam_cnt) && (r_cam[i] == r_id[w_sel])) w_cam_hit = 1'b1;
      w_drain    = w_any_elig && (w_cam_hit || !w_fifo_full);
      w_alert_wr = w_any_elig && !w_cam_hit && !w_fifo_full;
      w_sum_wr   = (r_state == ST_FLUSH) && !w_any_elig && !w_fifo_full;
      w_wr_rec   = mk_rec(REC_ALERT, r_tag[w_sel], PAY_W'({1'b0, r_id[w_sel]}));
      if (w_sum_wr)
         w_wr_rec = mk_rec(REC_SUMMARY, r_closing, {r_filter_seen, r_cam_ovf, r_ucnt});
      for (int i = 0; i < N_SRC; i++) begin
         w_load[i]     = (w_hit[i] != '0) && (!r_pend[i] || (w_drain && (w_sel == SEL_W'(i))));
         w_pend_nxt[i] = w_load[i] || (r_pend[i] && !(w_drain && (w_sel == SEL_W'(i))));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_COLLECT;
         r_closing     <= '0;
         r_pend        <= '0;
         r_cam_cnt     <= '0;
         r_ucnt        <= '0;
         r_filter_seen <= 1'b0;
         r_filter_next <= 1'b0;
         r_cam_ovf     <= 1'b0;
         busy          <= 1'b0;
         for (int i = 0; i < N_SRC; i++) begin
            r_id[i]  <= '0;
            r_tag[i] <= '0;
         end
         for (int i = 0; i < DEDUP_DEPTH; i++) r_cam[i] <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         busy   <= (|w_pend_nxt) || ((r_state == ST_COLLECT) && end_of_packet) ||
                   (r_state == ST_FLUSH);
         for (int i = 0; i < N_SRC; i++) begin
            if (w_load[i]) begin
               r_id[i]  <= w_hit[i];
               r_tag[i] <= cur_packet_id;
            end
         end
         if (w_alert_wr) begin
            if (r_cam_cnt < CAM_CW'(DEDUP_DEPTH)) begin
               r_cam[r_cam_cnt[CAM_IW-1:0]] <= r_id[w_sel];
               r_cam_cnt                    <= r_cam_cnt + CAM_CW'(1);
            end else begin
               r_cam_ovf <= 1'b1;
            end
            if (r_ucnt != '1) r_ucnt <= r_ucnt + UCNT_W'(1);
         end
         case (r_state)
            ST_COLLECT: begin
               if (filter_trigger) r_filter_seen <= 1'b1;
               if (end_of_packet) begin
                  r_closing <= cur_packet_id;
                  r_state   <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               if (filter_trigger) r_filter_next <= 1'b1;
               if (w_sum_wr)       r_state       <= ST_CLEAR;
            end
            default: begin
               // Triggers seen while closing belong to the packet that starts now
               r_cam_cnt     <= '0;
               r_ucnt        <= '0;
               r_cam_ovf     <= 1'b0;
               r_filter_seen <= r_filter_next || filter_trigger;
               r_filter_next <= 1'b0;
               r_state       <= ST_COLLECT;
            end
         endcase
      end
   end

`ifdef ALERT_DROP_CNT_EN
   localparam int unsigned DSUM_W = DROP_W + 1;
   logic [2:0]        w_ndrop;
   logic [DSUM_W-1:0] w_drop_sum;

   always_comb begin
      w_ndrop = '0;
      for (int i = 0; i < N_SRC; i++)
         if ((w_hit[i] != '0) && !w_load[i]) w_ndrop = w_ndrop + 3'd1;
      if (end_of_packet && (r_state != ST_COLLECT)) w_ndrop = w_ndrop + 3'd1;
      w_drop_sum = {1'b0, drop_count} + DSUM_W'(w_ndrop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) drop_count <= '0;
      else      drop_count <= w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
   end
`else
   assign drop_count = '0;
`endif

   alert_fifo #(
      .W     (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst),
      .i_wr_valid (w_alert_wr || w_sum_wr),
      .i_wr_data  (w_wr_rec),
      .o_full     (w_fifo_full),
      .o_rd_valid (alert_valid),
      .i_rd_ready (alert_ready),
      .o_rd_data  (alert_data)
   );
endmodule

// File: tb/tb_alert_collector.sv
// Directed bench for alert_collector: expected records are queued as stimulus is driven
// and compared in order as the collector hands them off.
module tb_alert_collector;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [10:0] hit_id0 = '0;
   logic [10:0] hit_id1 = '0;
   logic [10:0] hit_id2 = '0;
   logic [6:0]  cur_packet_id = '0;
   logic        end_of_packet = 1'b0;
   logic        filter_trigger = 1'b0;
   logic        alert_valid;
   logic        alert_ready = 1'b0;
   logic [19:0] alert_data;
   logic        busy;
   logic [7:0]  drop_count;

`ifdef ALERT_DROP_CNT_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   int          checks = 0;
   int          errors = 0;
   int          exp_drop = 0;
   logic [19:0] sb[$];

   alert_collector dut (
      .clk            (clk),
      .rst            (rst),
      .hit_id0        (hit_id0),
      .hit_id1        (hit_id1),
      .hit_id2        (hit_id2),
      .cur_packet_id  (cur_packet_id),
      .end_of_packet  (end_of_packet),
      .filter_trigger (filter_trigger),
      .alert_valid    (alert_valid),
      .alert_ready    (alert_ready),
      .alert_data     (alert_data),
      .busy           (busy),
      .drop_count     (drop_count)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] rec(input logic t, input logic [6:0] p, input logic [11:0] pay);
      return {t, p, pay};
   endfunction

   function automatic logic [11:0] summ(input logic fs, input logic ovf, input logic [9:0] n);
      return {fs, ovf, n};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_empty(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL drain_timeout: observed=%0d pending expected=0", sb.size());
      end
      tick_n(3);
   endtask

   task automatic check_drop(input string tag);
      check(tag, drop_count, DROP_EN ? exp_drop : 0);
   endtask

   // Consumer side: every accepted record must be the next expected one
   initial begin
      logic [19:0] e;
      forever begin
         @(negedge clk);
         if (rst && alert_valid && alert_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_record: observed=%h expected=none", alert_data);
            end
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("record", {12'h0, alert_data}, {12'h0, e});
            end
         end
      end
   end

   initial begin
      tick_n(3);
      rst = 1'b1;
      tick_n(2);
      check("rst_valid", alert_valid, 0);
      check("rst_data", alert_data, 0);
      check("rst_busy", busy, 0);
      check_drop("rst_drop");

      // Single hit, two-cycle latency, then summary
      alert_ready   = 1'b1;
      cur_packet_id = 7'd3;
      hit_id0       = 11'd5;
      sb.push_back(rec(1'b0, 7'd3, 12'd5));
      tick();
      check("lat_1cyc_valid", alert_valid, 0);
      hit_id0       = '0;
      end_of_packet = 1'b1;
      sb.push_back(rec(1'b1, 7'd3, summ(1'b0, 1'b0, 10'd1)));
      tick();
      end_of_packet = 1'b0;
      check("lat_2cyc_valid", alert_valid, 1);
      check("lat_2cyc_data", alert_data, rec(1'b0, 7'd3, 12'd5));
      check("busy_flush", busy, 1);
      wait_empty(50);
      check("busy_idle", busy, 0);

      // Dedup: same ID three times in one packet
      cur_packet_id = 7'd7;
      sb.push_back(rec(1'b0, 7'd7, 12'd42));
      for (int k = 0; k < 3; k++) begin
         hit_id1 = 11'd42;
         tick();
         hit_id1 = '0;
         tick();
      end
      end_of_packet = 1'b1;
      sb.push_back(rec(1'b1, 7'd7, summ(1'b0, 1'b0, 10'd1)));
      tick();
      end_of_packet = 1'b0;
      wait_empty(50);

      // Three sources in one cycle drain lowest index first over three cycles
      cur_packet_id = 7'd9;
      hit_id0 = 11'd10;
      hit_id1 = 11'd11;
      hit_id2 = 11'd12;
      sb.push_back(rec(1'b0, 7'd9, 12'd10));
      sb.push_back(rec(1'b0, 7'd9, 12'd11));
      sb.push_back(rec(1'b0, 7'd9, 12'd12));
      tick();
      hit_id0 = '0;
      hit_id1 = '0;
      hit_id2 = '0;
      tick_n(2);
      check("same_cyc_busy_2", busy, 1);
      tick();
      check("same_cyc_busy_3", busy, 0);
      end_of_packet = 1'b1;
      sb.push_back(rec(1'b1, 7'd9, summ(1'b0, 1'b0, 10'd3)));
      tick();
      end_of_packet = 1'b0;
      wait_empty(50);
      check_drop("same_cyc_drop");

      // Backpressure: 16 buffered, 17th held in staging, next hit on that source dropped
      alert_ready   = 1'b0;
      cur_packet_id = 7'd10;
      for (int k = 0; k < 17; k++) begin
         hit_id0 = 11'(100 + k);
         sb.push_back(rec(1'b0, 7'd10, 12'(100 + k)));
         tick();
      end
      hit_id0 = 11'd300;
      tick();
      hit_id0 = '0;
      exp_drop++;
      check_drop("bp_drop");
      check("bp_valid", alert_valid, 1);
      check("bp_head", alert_data, rec(1'b0, 7'd10, 12'd100));
      tick_n(4);
      check("bp_head_stable", alert_data, rec(1'b0, 7'd10, 12'd100));
      check("bp_busy", busy, 1);
      alert_ready = 1'b1;
      wait_empty(100);
      end_of_packet = 1'b1;
      sb.push_back(rec(1'b1, 7'd10, summ(1'b0, 1'b1, 10'd17)));
      tick();
      end_of_packet = 1'b0;
      wait_empty(50);

      // CAM overflow: ninth unique ID is not remembered, so its repeat alerts again
      cur_packet_id = 7'd20;
      for (int k = 0; k < 9; k++) begin
         hit_id0 = 11'(200 + k);
         sb.push_back(rec(1'b0, 7'd20, 12'(200 + k)));
         tick();
      end
      hit_id0 = 11'd208;
      sb.push_back(rec(1'b0, 7'd20, 12'd208));
      tick();
      hit_id0       = '0;
      end_of_packet = 1'b1;
      sb.push_back(rec(1'b1, 7'd20, summ(1'b0, 1'b1, 10'd10)));
      tick();
      end_of_packet = 1'b0;
      wait_empty(50);

      // Packet boundary: hit of packet 2 waits behind packet 1's summary
      cur_packet_id = 7'd1;
      end_of_packet = 1'b1;
      hit_id0       = 11'd30;
      sb.push_back(rec(1'b0, 7'd1, 12'd30));
      sb.push_back(rec(1'b1, 7'd1, summ(1'b0, 1'b0, 10'd1)));
      tick();
      cur_packet_id  = 7'd2;
      end_of_packet  = 1'b0;
      hit_id0        = '0;
      hit_id1        = 11'd31;
      filter_trigger = 1'b1;
      sb.push_back(rec(1'b0, 7'd2, 12'd31));
      tick();
      hit_id1        = '0;
      filter_trigger = 1'b0;
      end_of_packet  = 1'b1;
      exp_drop++;
      tick();
      end_of_packet = 1'b0;
      tick_n(4);
      end_of_packet = 1'b1;
      sb.push_back(rec(1'b1, 7'd2, summ(1'b1, 1'b0, 10'd1)));
      tick();
      end_of_packet = 1'b0;
      wait_empty(50);
      check_drop("boundary_drop");

      // Reset with records queued: everything discarded, nothing emitted afterwards
      alert_ready   = 1'b0;
      cur_packet_id = 7'd40;
      hit_id0 = 11'd50;
      hit_id1 = 11'd51;
      hit_id2 = 11'd52;
      tick();
      hit_id0 = '0;
      hit_id1 = '0;
      hit_id2 = '0;
      tick_n(5);
      check("pre_rst_valid", alert_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_valid", alert_valid, 0);
      check("mid_rst_data", alert_data, 0);
      check("mid_rst_busy", busy, 0);
      sb.delete();
      exp_drop = 0;
      check_drop("mid_rst_drop");
      tick_n(2);
      rst         = 1'b1;
      alert_ready = 1'b1;
      tick_n(20);
      check("post_rst_valid", alert_valid, 0);
      check("post_rst_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alert_collector.md
Name: alert_collector

Overview:
- Downstream of the option-processing stage. Consumes the per-cycle rule hits from the three option-type processors and the filter trigger.
- Deduplicates hits within a packet and buffers unique alerts.
- Emits alert and per-packet summary records over a valid/ready stream to the alert/report path.

Parameters:
RULE_W, 11, width of a rule ID; value 0 means "no hit"
PKT_W, 7, width of packet ID
DEDUP_DEPTH, 8, entries in the per-packet dedup CAM
FIFO_DEPTH, 16, output record FIFO depth (power of 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
hit_id0  in  RULE_W  rule hit from type-1 processor, 0 = none
hit_id1  in  RULE_W  rule hit from type-4 processor, 0 = none
hit_id2  in  RULE_W  rule hit from type-5 processor, 0 = none
cur_packet_id  in  PKT_W  packet owning hits presented this cycle
end_of_packet  in  1  one-cycle pulse; closes packet cur_packet_id
filter_trigger  in  1  filter-class match seen this cycle
alert_valid  out  1  alert_data valid
alert_ready  in  1  consumer accepts
alert_data  out  20  [19] type (0 alert, 1 summary), [18:12] pkt ID, [11:0] payload
busy  out  1  staging non-empty or FSM not in COLLECT
drop_count  out  8  dropped-hit counter (see Optional Feature)

Behaviour:
- Reset (rst low, async) clears:
  - alert_valid=0, alert_data=0, busy=0, drop_count=0
  - staging empty, CAM empty, FIFO empty
  - unique_count=0, filter_seen=0, cam_ovf=0; FSM=COLLECT
- Staging:
  - One slot per source: pending, id, pkt tag.
  - A nonzero hit_idN loads slot N with cur_packet_id as tag if the slot is empty, or is being drained in the same cycle.
  - Otherwise the hit is dropped and drop_count increments, saturating at 255.
- Arbiter:
  - Each cycle, the lowest-index eligible pending slot is selected.
  - In COLLECT, every pending slot is eligible.
  - In FLUSH, only slots whose tag equals the closing ID are eligible.
- Drain of the selected slot:
  - ID found in CAM: discard, slot cleared, no write.
  - ID not found and FIFO not full: write alert record with payload {1'b0, id}. Insert into CAM if not full, else set cam_ovf. unique_count++ (10-bit, saturating). Slot cleared.
  - FIFO full: slot stays pending (backpressure); no drop.
- filter_trigger=1 in any cycle sets filter_seen.
- FSM COLLECT:
  - On end_of_packet, latch closing_id=cur_packet_id and go to FLUSH.
  - Hits in the end_of_packet cycle belong to the closing packet.
- FSM FLUSH:
  - Stays while any slot tagged closing_id is pending.
  - Then, when FIFO not full, write summary payload {filter_seen, cam_ovf, unique_count} and go to CLEAR.
  - FIFO full: wait in FLUSH.
- FSM CLEAR (1 cycle): clear CAM, unique_count, filter_seen, cam_ovf; go to COLLECT.
- Events arriving outside COLLECT:
  - end_of_packet in FLUSH or CLEAR is ignored and counted as a drop.
  - filter_trigger in FLUSH or CLEAR is credited to the next packet.
- Output stream:
  - Standard valid/ready; alert_data is held stable while alert_valid && !alert_ready.
  - FIFO write-to-alert_valid latency is 1 cycle.
  - Simultaneous write and read when full is not allowed; full blocks the write.
- Latency: a hit on an idle source reaches alert_valid after 2 cycles (staging, FIFO).
- Reset mid-packet: all state discarded; no summary is emitted for the interrupted packet.

Optional Feature:
- Macro ALERT_DROP_CNT_EN.
- Defined: drop_count register as specified.
- Undefined: drop_count is tied to 0 and the counter logic is removed; drops still occur silently.

Decomposition:
- Package alert_pkg holds:
  - RULE_W and PKT_W defaults
  - record field offsets and the type-bit encodings
  - FSM state encoding (COLLECT, FLUSH, CLEAR)
- Sub-module alert_fifo: synchronous FIFO with registered output, full/empty and valid/ready interface, parameterised on width and depth.
- The CAM stays inline.

Test Plan:
- Single hit: hit_id0=5 on packet 3, then end_of_packet, ready=1 → record {0,3,0x005}, then summary {1,3,unique_count=1, filter_seen=0, cam_ovf=0}.
- Dedup: hit_id1=42 on three separate cycles within packet 7 → one alert {0,7,42}; summary count=1.
- Same-cycle hits: hit_id0=10, hit_id1=11, hit_id2=12 → alerts in order 10, 11, 12; 3 cycles of drain; no drops.
- Backpressure: alert_ready=0 with 17 unique hits spaced 1 cycle apart → 16 records buffered, the 17th pending in staging; a later hit on the same source is dropped and drop_count=1 (with ALERT_DROP_CNT_EN). After ready=1, all 17 alerts are delivered with no loss or reordering.
- CAM overflow: 9 unique IDs, then a repeat of ID #9 → 10 alerts emitted; summary cam_ovf=1, count=10.
- Packet boundary: end_of_packet for packet 1 while a hit tagged packet 2 is pending → summary for 1 precedes the alert for 2; filter_trigger during FLUSH sets filter_seen only in packet 2's summary.
- Reset mid-operation: assert rst low with records in the FIFO → alert_valid=0 immediately; no summary afterwards.
